// File: rtl/chip_ledger_pkg.sv
// chip_ledger_pkg: shared poker types, chip width and a clamp helper for the chip ledger.
package chip_ledger_pkg;
  localparam int CHIP_W = 11;
  typedef logic [CHIP_W-1:0] chips_t;
  typedef enum logic [2:0] {HS_IDLE, HS_DEAL, HS_FLOP, HS_TURN, HS_RIVER, HS_SHOWDOWN} hand_state_t;
  typedef enum logic [1:0] {ACT_CHECK, ACT_CALL, ACT_RAISE, ACT_FOLD} bet_action_t;
  typedef enum logic [2:0] {IDLE, POST_ANTE, POST_SB, POST_BB, BETTING, AWARD, DONE} ledger_state_t;
  function automatic chips_t min_chips(input chips_t a, input chips_t b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/chip_ledger_bet_calc.sv
// bet_calc: legality and stack-clamped transfer amount for one betting action.
module bet_calc
  import chip_ledger_pkg::*;
#(
  parameter int BIG_BLIND = 10
) (
  input  chips_t      stack,
  input  chips_t      own_pot,
  input  chips_t      opp_pot,
  input  bet_action_t action,
  input  chips_t      raise_amt,
  output chips_t      amount,
  output logic        legal,
  output logic        all_in
);
  chips_t d;
  logic [CHIP_W:0] want;
  assign d = opp_pot > own_pot ? opp_pot - own_pot : '0;
  always_comb begin
    want = action == ACT_RAISE ? {1'b0, d} + {1'b0, raise_amt} : action == ACT_CALL ? {1'b0, d} : '0;
    all_in = action inside {ACT_CALL, ACT_RAISE} && want >= {1'b0, stack};
    amount = all_in ? stack : want[CHIP_W-1:0];
    legal = action == ACT_CHECK ? d == '0 :
            action == ACT_CALL  ? d != '0 :
            action == ACT_RAISE ? stack > d && (raise_amt >= CHIP_W'(BIG_BLIND) || all_in) : 1'b1;
  end
endmodule

// File: rtl/chip_ledger.sv
// chip_ledger: stacks, street bets and pot for a heads-up hand; posts blinds, applies actions, pays out.
// Define ANTE_EN to add an ante round (parameter ANTE) ahead of the blinds.
module chip_ledger
  import chip_ledger_pkg::*;
#(
  parameter int START_STACK = 1000,
  parameter int SMALL_BLIND = 5,
  parameter int BIG_BLIND = 10
`ifdef ANTE_EN
  , parameter int ANTE = 1
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_hand,
  input  logic              dealer,
  input  logic              action_valid,
  output logic              action_ready,
  input  logic              action_player,
  input  logic [1:0]        action_type,
  input  logic [CHIP_W-1:0] raise_amt,
  input  logic              street_end,
  input  logic              award_valid,
  input  logic              award_winner,
  input  logic              award_tie,
  output logic [CHIP_W-1:0] player_stacks [2],
  output logic [CHIP_W-1:0] player_pots [2],
  output logic [CHIP_W-1:0] pot_size,
  output logic              action_done,
  output logic              action_error,
  output logic              hand_over,
  output logic              winner
);
  ledger_state_t state, next_state;
  logic dealer_r, cool, tie_r, acc, award_acc, fold, legal, unused_all_in;
  chips_t amt, sb_amt, bb_amt, half, win_pay, lose_pay;
  bet_action_t act;
  assign act = bet_action_t'(action_type);
  assign action_ready = state == BETTING && !cool;
  assign acc = action_valid && action_ready;
  assign award_acc = award_valid && state == BETTING && !acc;
  assign fold = acc && act == ACT_FOLD;
  assign hand_over = state == DONE;
  assign sb_amt = min_chips(CHIP_W'(SMALL_BLIND), player_stacks[dealer_r]);
  assign bb_amt = min_chips(CHIP_W'(BIG_BLIND), player_stacks[~dealer_r]);
  // On a split the non-dealer is the latched winner and so collects the odd chip.
  assign half = pot_size >> 1;
  assign win_pay = tie_r ? pot_size - half : pot_size;
  assign lose_pay = tie_r ? half : '0;
`ifdef ANTE_EN
  localparam ledger_state_t FIRST_POST = POST_ANTE;
  chips_t ante_amt [2];
  assign ante_amt[0] = min_chips(CHIP_W'(ANTE), player_stacks[0]);
  assign ante_amt[1] = min_chips(CHIP_W'(ANTE), player_stacks[1]);
`else
  localparam ledger_state_t FIRST_POST = POST_SB;
`endif
  bet_calc #(.BIG_BLIND(BIG_BLIND)) u_calc (
    .stack    (player_stacks[action_player]),
    .own_pot  (player_pots[action_player]),
    .opp_pot  (player_pots[~action_player]),
    .action   (act),
    .raise_amt(raise_amt),
    .amount   (amt),
    .legal    (legal),
    .all_in   (unused_all_in)
  );
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: next_state = new_hand ? FIRST_POST : state;
      POST_ANTE:  next_state = POST_SB;
      POST_SB:    next_state = POST_BB;
      POST_BB:    next_state = BETTING;
      BETTING:    next_state = fold || award_acc ? AWARD : BETTING;
      AWARD:      next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      player_stacks <= '{default: CHIP_W'(START_STACK)};
      player_pots <= '{default: '0};
      pot_size <= '0;
      winner <= 1'b0;
      dealer_r <= 1'b0;
      cool <= 1'b0;
      tie_r <= 1'b0;
      action_done <= 1'b0;
      action_error <= 1'b0;
    end else begin
      state <= next_state;
      cool <= acc;
      action_done <= acc && legal;
      action_error <= acc && !legal;
      case (state)
        IDLE, DONE: if (new_hand) dealer_r <= dealer;
`ifdef ANTE_EN
        POST_ANTE: begin
          player_stacks[0] <= player_stacks[0] - ante_amt[0];
          player_stacks[1] <= player_stacks[1] - ante_amt[1];
          pot_size <= pot_size + ante_amt[0] + ante_amt[1];
        end
`endif
        POST_SB: begin
          player_stacks[dealer_r] <= player_stacks[dealer_r] - sb_amt;
          player_pots[dealer_r] <= player_pots[dealer_r] + sb_amt;
          pot_size <= pot_size + sb_amt;
        end
        POST_BB: begin
          player_stacks[~dealer_r] <= player_stacks[~dealer_r] - bb_amt;
          player_pots[~dealer_r] <= player_pots[~dealer_r] + bb_amt;
          pot_size <= pot_size + bb_amt;
        end
        BETTING: begin
          if (acc && legal) begin
            player_stacks[action_player] <= player_stacks[action_player] - amt;
            player_pots[action_player] <= player_pots[action_player] + amt;
            pot_size <= pot_size + amt;
            if (fold) begin
              winner <= ~action_player;
              tie_r <= 1'b0;
            end
          end else if (award_acc) begin
            winner <= award_tie ? ~dealer_r : award_winner;
            tie_r <= award_tie;
          end else if (street_end && !acc) begin
            player_pots <= '{default: '0};
          end
        end
        AWARD: begin
          player_stacks[winner] <= player_stacks[winner] + win_pay;
          player_stacks[~winner] <= player_stacks[~winner] + lose_pay;
          player_pots <= '{default: '0};
          pot_size <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chip_ledger.sv
// tb_chip_ledger: directed and randomized hands checked against a chip-accounting reference model.
module tb_chip_ledger;
  import chip_ledger_pkg::*;
`ifdef ANTE_EN
  localparam int AN = 1;
`else
  localparam int AN = 0;
`endif
  logic clk = 1'b0;
  logic rst, new_hand, dealer, action_valid, action_player, street_end, award_valid, award_winner, award_tie;
  logic [1:0] action_type;
  logic [10:0] raise_amt;
  logic [10:0] player_stacks [2];
  logic [10:0] player_pots [2];
  logic [10:0] pot_size;
  logic action_ready, action_done, action_error, hand_over, winner;
  int st[2], pt[2], pot, win, dl;
  int nvec = 0, nerr = 0;

  chip_ledger dut (
    .clk(clk), .rst(rst), .new_hand(new_hand), .dealer(dealer),
    .action_valid(action_valid), .action_ready(action_ready), .action_player(action_player),
    .action_type(action_type), .raise_amt(raise_amt), .street_end(street_end),
    .award_valid(award_valid), .award_winner(award_winner), .award_tie(award_tie),
    .player_stacks(player_stacks), .player_pots(player_pots), .pot_size(pot_size),
    .action_done(action_done), .action_error(action_error), .hand_over(hand_over), .winner(winner)
  );

  always #5 clk = ~clk;

  function automatic int mn(input int a, input int b);
    return a < b ? a : b;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_stack0"}, int'(player_stacks[0]), st[0]);
    chk({tag, "_stack1"}, int'(player_stacks[1]), st[1]);
    chk({tag, "_pot0"}, int'(player_pots[0]), pt[0]);
    chk({tag, "_pot1"}, int'(player_pots[1]), pt[1]);
    chk({tag, "_pot_size"}, int'(pot_size), pot);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("conservation", int'(player_stacks[0]) + int'(player_stacks[1]) + int'(pot_size), 2000);
  endtask

  task automatic model_reset();
    st[0] = 1000; st[1] = 1000; pt[0] = 0; pt[1] = 0; pot = 0; win = 0;
  endtask

  task automatic payout(input bit tie);
    int h;
    h = pot / 2;
    if (tie) begin
      st[dl] += h;
      st[1-dl] += pot - h;
    end else st[win] += pot;
    pot = 0; pt[0] = 0; pt[1] = 0;
  endtask

  task automatic start_hand(input int d);
    int n, a;
    dealer = d[0]; new_hand = 1'b1;
    tick();
    new_hand = 1'b0; dealer = 1'b0;
    n = 0;
    while (!action_ready && n < 10) begin
      tick();
      n++;
    end
    chk("start_latency", n, 2 + AN);
    dl = d;
    for (int i = 0; i < 2; i++) begin
      a = mn(AN, st[i]); st[i] -= a; pot += a;
    end
    a = mn(5, st[dl]); st[dl] -= a; pt[dl] += a; pot += a;
    a = mn(10, st[1-dl]); st[1-dl] -= a; pt[1-dl] += a; pot += a;
    chk_all("blinds");
  endtask

  task automatic act(input int p, input int t, input int r, input bit noise);
    int d, amt;
    bit lg;
    action_valid = 1'b1; action_player = p[0]; action_type = t[1:0]; raise_amt = r[10:0];
    street_end = noise; award_valid = noise; award_winner = ~p[0]; award_tie = 1'b0;
    tick();
    action_valid = 1'b0; street_end = 1'b0; award_valid = 1'b0;
    d = pt[1-p] > pt[p] ? pt[1-p] - pt[p] : 0;
    amt = 0;
    case (t)
      ACT_CHECK: lg = d == 0;
      ACT_CALL:  begin lg = d > 0; amt = mn(d, st[p]); end
      ACT_RAISE: begin amt = mn(d + r, st[p]); lg = st[p] > d && (r >= 10 || amt == st[p]); end
      default:   lg = 1'b1;
    endcase
    chk("action_done", action_done, lg);
    chk("action_error", action_error, !lg);
    if (lg) begin
      st[p] -= amt; pt[p] += amt; pot += amt;
    end
    chk_all("action");
    chk("ready_gap", action_ready, 0);
    tick();
    if (t == ACT_FOLD) begin
      win = 1 - p;
      payout(1'b0);
      chk("fold_winner", winner, win);
      chk("fold_hand_over", hand_over, 1);
      chk_all("fold_pay");
    end else chk("ready_back", action_ready, 1);
  endtask

  task automatic award(input int w, input bit tie);
    award_valid = 1'b1; award_winner = w[0]; award_tie = tie;
    tick();
    award_valid = 1'b0; award_tie = 1'b0;
    win = tie ? 1 - dl : w;
    chk("award_not_done_yet", hand_over, 0);
    tick();
    payout(tie);
    chk("award_winner", winner, win);
    chk("award_hand_over", hand_over, 1);
    chk_all("award");
  endtask

  task automatic street();
    street_end = 1'b1;
    tick();
    street_end = 1'b0;
    pt[0] = 0; pt[1] = 0;
    chk_all("street_end");
  endtask

  initial begin
    bit fin;
    int t, r;
    rst = 1'b1; new_hand = 0; dealer = 0; action_valid = 0; action_player = 0; action_type = 0;
    raise_amt = 0; street_end = 0; award_valid = 0; award_winner = 0; award_tie = 0;
    model_reset();
    tick(); tick();
    chk_all("reset");
    chk("reset_winner", winner, 0);
    chk("reset_hand_over", hand_over, 0);
    chk("reset_ready", action_ready, 0);
    chk("reset_done", action_done, 0);
    chk("reset_error", action_error, 0);
    rst = 1'b0;
    tick();
    start_hand(0);
    chk("blind_pot", int'(pot_size), 15 + 2 * AN);
    act(0, ACT_CHECK, 0, 0);
    act(0, ACT_CALL, 0, 0);
    act(1, ACT_RAISE, 4, 0);
    act(1, ACT_RAISE, 30, 0);
    act(0, ACT_FOLD, 0, 0);
    action_valid = 1'b1; action_type = ACT_CHECK;
    tick();
    action_valid = 1'b0;
    chk("done_ignore_error", action_error, 0);
    chk("done_ignore_done", action_done, 0);
    chk_all("done_ignore");
    start_hand(1);
    act(1, ACT_RAISE, 2000, 0);
    act(0, ACT_CALL, 0, 0);
    award(1, 1'b1);
    start_hand(0);
    act(0, ACT_CALL, 0, 0);
    street();
    act(0, ACT_RAISE, 11, 0);
    new_hand = 1'b1; dealer = 1'b1;
    tick();
    new_hand = 1'b0; dealer = 1'b0;
    chk("new_hand_ignored", action_ready, 1);
    chk_all("new_hand_ignored");
    award(0, 1'b1);
    start_hand(1);
    act(1, ACT_CALL, 0, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_all("async_reset");
    chk("async_reset_ready", action_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    for (int h = 0; h < 40; h++) begin
      start_hand(int'($urandom % 2));
      fin = 1'b0;
      for (int k = 0; k < 16 && !fin; k++) begin
        r = int'($urandom % 16);
        if (r == 0) begin
          award(int'($urandom % 2), $urandom % 4 == 0);
          fin = 1'b1;
        end else if (r == 1) street();
        else begin
          r = int'($urandom % 10);
          t = r < 3 ? ACT_CHECK : r < 6 ? ACT_CALL : r < 9 ? ACT_RAISE : ACT_FOLD;
          r = $urandom % 8 == 0 ? int'($urandom % 2048) : int'($urandom % 40);
          act(int'($urandom % 2), t, r, $urandom % 4 == 0);
          fin = t == ACT_FOLD;
        end
      end
      if (!fin) award(int'($urandom % 2), $urandom % 3 == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
